// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the fetch unit: instruction-memory read port plus the
// valid/ready hand-off to the instruction queue. Master = fetch unit side.
interface instr_fetch_unit_if;
    logic [31:0] instr_mem_address;
    logic        instr_read;
    logic [31:0] instr_mem_rdata;
    logic        instr_mem_resp;
    logic        iq_valid;
    logic [31:0] iq_instr;
    logic [31:0] iq_pc;
    logic        iq_ready;

    modport master (
        output instr_mem_address, instr_read, iq_valid, iq_instr, iq_pc,
        input  instr_mem_rdata, instr_mem_resp, iq_ready
    );

    modport slave (
        input  instr_mem_address, instr_read, iq_valid, iq_instr, iq_pc,
        output instr_mem_rdata, instr_mem_resp, iq_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequential PC generation, one outstanding memory read, and a
// small {instr,pc} FIFO toward the IQ. Define IFU_PERF_EN for perf counters.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h4000_0060,
    localparam int         PTR_W    = $clog2(DEPTH),
    localparam int         CNT_W    = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_unit_if.master   bus,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [CNT_W-1:0]     fifo_count
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {FETCH, STALL, DISCARD} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_t             state, state_next;
    logic [31:0]        pc;
    logic [31:0]        hold_addr;
    entry_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_next;
    logic               push, pop, room;

    // Redirect squashes both the incoming word and any pop in the same cycle.
    assign push = (state == FETCH) && bus.instr_mem_resp && !redirect;
    assign pop  = (count != '0) && bus.iq_ready && !redirect;

    always_comb begin
        count_next = count;
        if (redirect)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CNT_W'(1);
        else if (pop && !push)
            count_next = count - CNT_W'(1);
    end

    assign room = (count_next < CNT_W'(DEPTH));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        state_next            = state;
        bus.instr_read        = 1'b1;
        bus.instr_mem_address = pc;
        unique case (state)
            FETCH: begin
                if (redirect)
                    state_next = bus.instr_mem_resp ? FETCH : DISCARD;
                else
                    state_next = room ? FETCH : STALL;
            end
            STALL: begin
                bus.instr_read = 1'b0;
                state_next     = (redirect || room) ? FETCH : STALL;
            end
            DISCARD: begin
                bus.instr_mem_address = hold_addr;
                if (bus.instr_mem_resp)
                    state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            hold_addr <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (redirect) begin
                pc     <= redirect_pc & 32'hFFFF_FFFC;
                wr_ptr <= '0;
                rd_ptr <= '0;
                // The in-flight read keeps its original address until it returns.
                if (state == FETCH)
                    hold_addr <= pc;
            end else begin
                if (push) begin
                    pc     <= pc + 32'd4;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: FIFO storage is not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{instr: bus.instr_mem_rdata, pc: pc};
    end

    assign bus.iq_valid = (count != '0);
    assign bus.iq_instr = fifo_mem[rd_ptr].instr;
    assign bus.iq_pc    = fifo_mem[rd_ptr].pc;
    assign fifo_count   = count;

`ifdef IFU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (push && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == STALL && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, stall/backpressure,
// redirect handling, and back-to-back push/pop across pointer wrap.
module tb_instr_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h4000_0060;
    localparam logic [31:0] KEY      = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  fifo_count;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int passed = 0;
    int total  = 0;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fifo_count  (fifo_count)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        redirect            = 1'b0;
        redirect_pc         = 32'h0;
        bus.instr_mem_resp  = 1'b0;
        bus.instr_mem_rdata = 32'h0;
        bus.iq_ready        = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.instr_read !== 1'b1) $display("FAIL reset_read: got %0b want 1", bus.instr_read); else passed++;
        total++; if (bus.instr_mem_address !== RESET_PC) $display("FAIL reset_addr: got %h want %h", bus.instr_mem_address, RESET_PC); else passed++;
        total++; if (bus.iq_valid !== 1'b0) $display("FAIL reset_iq_valid: got %0b want 0", bus.iq_valid); else passed++;
        total++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fifo_count); else passed++;
    endtask

    // Resp every second cycle, IQ always ready.
    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        bus.iq_ready = 1'b1;
        exp_pc = RESET_PC;
        for (int k = 0; k < 4; k++) begin
            total++; if (bus.instr_mem_address !== exp_pc) $display("FAIL seq_addr%0d: got %h want %h", k, bus.instr_mem_address, exp_pc); else passed++;
            step();
            total++; if (bus.instr_mem_address !== exp_pc || bus.instr_read !== 1'b1) $display("FAIL seq_hold%0d: got %h/%0b want %h/1", k, bus.instr_mem_address, bus.instr_read, exp_pc); else passed++;
            bus.instr_mem_resp  = 1'b1;
            bus.instr_mem_rdata = exp_pc ^ KEY;
            step();
            bus.instr_mem_resp = 1'b0;
            total++; if (bus.iq_valid !== 1'b1 || bus.iq_pc !== exp_pc) $display("FAIL seq_iq%0d: got v=%0b pc=%h want v=1 pc=%h", k, bus.iq_valid, bus.iq_pc, exp_pc); else passed++;
            total++; if (bus.iq_instr !== (exp_pc ^ KEY)) $display("FAIL seq_instr%0d: got %h want %h", k, bus.iq_instr, exp_pc ^ KEY); else passed++;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    // Backpressure fills the FIFO, then a single pop releases the stall.
    task automatic test_stall();
        logic [31:0] exp_pc;
        do_reset();
        exp_pc = RESET_PC;
        for (int k = 0; k < 4; k++) begin
            bus.instr_mem_resp  = 1'b1;
            bus.instr_mem_rdata = exp_pc ^ KEY;
            step();
            exp_pc = exp_pc + 32'd4;
        end
        bus.instr_mem_resp = 1'b0;
        total++; if (fifo_count !== 3'd4) $display("FAIL stall_count: got %0d want 4", fifo_count); else passed++;
        total++; if (bus.instr_read !== 1'b0) $display("FAIL stall_read: got %0b want 0", bus.instr_read); else passed++;
        total++; if (bus.iq_pc !== RESET_PC) $display("FAIL stall_head: got %h want %h", bus.iq_pc, RESET_PC); else passed++;
        step();
        step();
        total++; if (bus.instr_read !== 1'b0 || fifo_count !== 3'd4) $display("FAIL stall_hold: got rd=%0b cnt=%0d want rd=0 cnt=4", bus.instr_read, fifo_count); else passed++;
        bus.iq_ready = 1'b1;
        step();
        bus.iq_ready = 1'b0;
        total++; if (fifo_count !== 3'd3) $display("FAIL unstall_count: got %0d want 3", fifo_count); else passed++;
        total++; if (bus.instr_read !== 1'b1 || bus.instr_mem_address !== 32'h4000_0070) $display("FAIL unstall_req: got rd=%0b addr=%h want rd=1 addr=40000070", bus.instr_read, bus.instr_mem_address); else passed++;
        total++; if (bus.iq_pc !== 32'h4000_0064 || bus.iq_instr !== (32'h4000_0064 ^ KEY)) $display("FAIL unstall_head: got %h/%h want 40000064/%h", bus.iq_pc, bus.iq_instr, 32'h4000_0064 ^ KEY); else passed++;
`ifdef IFU_PERF_EN
        total++; if (perf_fetch_cnt !== 32'd4) $display("FAIL perf_fetch: got %0d want 4", perf_fetch_cnt); else passed++;
        total++; if (perf_stall_cnt !== 32'd3) $display("FAIL perf_stall: got %0d want 3", perf_stall_cnt); else passed++;
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0300;
        step();
        redirect = 1'b0;
        total++; if (perf_fetch_cnt !== 32'd4 || perf_stall_cnt !== 32'd3) $display("FAIL perf_redirect: got %0d/%0d want 4/3", perf_fetch_cnt, perf_stall_cnt); else passed++;
`endif
    endtask

    // Redirect while a read is outstanding and three words are buffered.
    task automatic test_redirect_pending();
        logic [31:0] exp_pc;
        do_reset();
        exp_pc = RESET_PC;
        for (int k = 0; k < 3; k++) begin
            bus.instr_mem_resp  = 1'b1;
            bus.instr_mem_rdata = exp_pc ^ KEY;
            step();
            exp_pc = exp_pc + 32'd4;
        end
        bus.instr_mem_resp = 1'b0;
        total++; if (fifo_count !== 3'd3 || bus.instr_mem_address !== 32'h4000_006C) $display("FAIL pend_pre: got cnt=%0d addr=%h want cnt=3 addr=4000006c", fifo_count, bus.instr_mem_address); else passed++;
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0103;
        step();
        redirect = 1'b0;
        total++; if (bus.iq_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL pend_flush: got v=%0b cnt=%0d want v=0 cnt=0", bus.iq_valid, fifo_count); else passed++;
        total++; if (bus.instr_read !== 1'b1 || bus.instr_mem_address !== 32'h4000_006C) $display("FAIL pend_hold: got rd=%0b addr=%h want rd=1 addr=4000006c", bus.instr_read, bus.instr_mem_address); else passed++;
        step();
        total++; if (bus.instr_mem_address !== 32'h4000_006C) $display("FAIL pend_hold2: got %h want 4000006c", bus.instr_mem_address); else passed++;
        bus.instr_mem_resp  = 1'b1;
        bus.instr_mem_rdata = 32'h1234_5678;
        step();
        bus.instr_mem_resp = 1'b0;
        total++; if (fifo_count !== 3'd0 || bus.iq_valid !== 1'b0) $display("FAIL pend_drop: got cnt=%0d v=%0b want cnt=0 v=0", fifo_count, bus.iq_valid); else passed++;
        total++; if (bus.instr_read !== 1'b1 || bus.instr_mem_address !== 32'h4000_0100) $display("FAIL pend_newreq: got rd=%0b addr=%h want rd=1 addr=40000100", bus.instr_read, bus.instr_mem_address); else passed++;
        bus.instr_mem_resp  = 1'b1;
        bus.instr_mem_rdata = 32'h4000_0100 ^ KEY;
        step();
        bus.instr_mem_resp = 1'b0;
        total++; if (bus.iq_valid !== 1'b1 || bus.iq_pc !== 32'h4000_0100 || bus.iq_instr !== (32'h4000_0100 ^ KEY)) $display("FAIL pend_push: got v=%0b pc=%h ins=%h want v=1 pc=40000100 ins=%h", bus.iq_valid, bus.iq_pc, bus.iq_instr, 32'h4000_0100 ^ KEY); else passed++;
    endtask

    // Redirect coinciding with resp and pop, then a double redirect in DISCARD.
    task automatic test_redirect_with_resp();
        do_reset();
        bus.instr_mem_resp  = 1'b1;
        bus.instr_mem_rdata = RESET_PC ^ KEY;
        step();
        total++; if (fifo_count !== 3'd1) $display("FAIL rr_pre: got %0d want 1", fifo_count); else passed++;
        redirect            = 1'b1;
        redirect_pc         = 32'h4000_0200;
        bus.iq_ready        = 1'b1;
        bus.instr_mem_rdata = 32'hCAFE_0000;
        step();
        redirect           = 1'b0;
        bus.instr_mem_resp = 1'b0;
        bus.iq_ready       = 1'b0;
        total++; if (fifo_count !== 3'd0 || bus.iq_valid !== 1'b0) $display("FAIL rr_flush: got cnt=%0d v=%0b want cnt=0 v=0", fifo_count, bus.iq_valid); else passed++;
        total++; if (bus.instr_read !== 1'b1 || bus.instr_mem_address !== 32'h4000_0200) $display("FAIL rr_newreq: got rd=%0b addr=%h want rd=1 addr=40000200", bus.instr_read, bus.instr_mem_address); else passed++;
        redirect    = 1'b1;
        redirect_pc = 32'h4000_0300;
        step();
        redirect_pc = 32'h4000_0402;
        step();
        redirect = 1'b0;
        total++; if (bus.instr_mem_address !== 32'h4000_0200 || bus.instr_read !== 1'b1) $display("FAIL rr_discard_hold: got rd=%0b addr=%h want rd=1 addr=40000200", bus.instr_read, bus.instr_mem_address); else passed++;
        bus.instr_mem_resp = 1'b1;
        step();
        bus.instr_mem_resp = 1'b0;
        total++; if (bus.instr_mem_address !== 32'h4000_0400 || fifo_count !== 3'd0) $display("FAIL rr_second: got addr=%h cnt=%0d want addr=40000400 cnt=0", bus.instr_mem_address, fifo_count); else passed++;
    endtask

    // Push and pop every cycle for 20 words; pointers wrap several times.
    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        do_reset();
        bus.iq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_pc = RESET_PC + 32'(4 * i);
            total++; if (bus.instr_mem_address !== exp_pc) $display("FAIL b2b_addr%0d: got %h want %h", i, bus.instr_mem_address, exp_pc); else passed++;
            bus.instr_mem_resp  = 1'b1;
            bus.instr_mem_rdata = exp_pc ^ KEY;
            step();
            total++; if (bus.iq_valid !== 1'b1 || bus.iq_pc !== exp_pc || bus.iq_instr !== (exp_pc ^ KEY)) $display("FAIL b2b_head%0d: got v=%0b pc=%h ins=%h want v=1 pc=%h", i, bus.iq_valid, bus.iq_pc, bus.iq_instr, exp_pc); else passed++;
            total++; if (fifo_count !== 3'd1) $display("FAIL b2b_count%0d: got %0d want 1", i, fifo_count); else passed++;
        end
        bus.instr_mem_resp = 1'b0;
        step();
        total++; if (bus.iq_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL b2b_drain: got v=%0b cnt=%0d want v=0 cnt=0", bus.iq_valid, fifo_count); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_pending();
        test_redirect_with_resp();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
